// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//   Shares one single-port framebuffer RAM between the VGA prefetcher
//   (read-only, priority) and the CPU video-memory bus (reads and byte-masked
//   writes). A bounded VGA streak counter forces the CPU in after VGA_BURST
//   consecutive VGA grants while the CPU is waiting.
//
//   Access sequence: IDLE -> ISSUE -> WAIT (reads only) -> ACK -> GAP -> IDLE.
//
// Ports
//   sys_clk, reset        clock; asynchronous active-high reset
//   vga_access/_address   prefetch read request (held until vga_ack)
//   vga_ack, vga_data     one-cycle completion pulse, read data
//   cpu_access, cpu_wr_en, cpu_address, cpu_bytesel, cpu_wr_data
//                         CPU request (held until cpu_ack, maybe one cycle more)
//   cpu_ack, cpu_data     one-cycle completion pulse, read data
//   ram_address, ram_wr_en, ram_bytesel, ram_wr_data
//                         registered RAM command outputs
//   ram_rd_data           RAM read data, valid RAM_LATENCY cycles after address
// -----------------------------------------------------------------------------
module fb_arbiter #(
  parameter int RAM_LATENCY = 1,
  parameter int VGA_BURST   = 8
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        vga_access,
  input  logic [15:0] vga_address,
  output logic        vga_ack,
  output logic [15:0] vga_data,
  input  logic        cpu_access,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_address,
  input  logic [1:0]  cpu_bytesel,
  input  logic [15:0] cpu_wr_data,
  output logic        cpu_ack,
  output logic [15:0] cpu_data,
  output logic [15:0] ram_address,
  output logic        ram_wr_en,
  output logic [1:0]  ram_bytesel,
  output logic [15:0] ram_wr_data,
  input  logic [15:0] ram_rd_data
);

  localparam int STREAK_W = $clog2(VGA_BURST + 1);
  localparam int WAIT_W   = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VGA_BURST);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD  = WAIT_W'(RAM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_cpu_q;   // 1: current access belongs to the CPU
  logic                is_write_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [STREAK_W-1:0] streak_q;

  logic grant_vga;
  logic grant_cpu;
  logic capture;

  // Next-state and grant decode.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d   = state_q;
    grant_vga = 1'b0;
    grant_cpu = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // VGA has priority unless the CPU has already waited out a full streak.
        if (cpu_access && (!vga_access || streak_q == STREAK_MAX)) begin
          grant_cpu = 1'b1;
        end else if (vga_access) begin
          grant_vga = 1'b1;
        end
        if (grant_cpu || grant_vga) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = is_write_q ? S_ACK : S_WAIT;
      S_WAIT: begin
        // Read data is valid in the last WAIT cycle.
        if (wait_cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_GAP;
      // One dead cycle so a requester still holding access right after its
      // ack is not granted a second time.
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_cpu_q <= 1'b0;
      is_write_q  <= 1'b0;
      wait_cnt_q  <= '0;
      streak_q    <= '0;
      ram_address <= '0;
      ram_wr_en   <= 1'b0;
      ram_bytesel <= '0;
      ram_wr_data <= '0;
      vga_data    <= '0;
      cpu_data    <= '0;
    end else begin
      state_q <= state_d;

      // The write strobe is set only by a CPU write grant, so it is high for
      // exactly the ISSUE cycle that follows.
      ram_wr_en <= grant_cpu && cpu_wr_en;

      if (grant_cpu) begin
        owner_cpu_q <= 1'b1;
        is_write_q  <= cpu_wr_en;
        ram_address <= cpu_address;
        ram_bytesel <= cpu_bytesel;
        ram_wr_data <= cpu_wr_data;
      end else if (grant_vga) begin
        owner_cpu_q <= 1'b0;
        is_write_q  <= 1'b0;
        ram_address <= vga_address;
        ram_bytesel <= 2'b11;
      end

      if (state_q == S_ISSUE) begin
        wait_cnt_q <= WAIT_LOAD;
      end else if (state_q == S_WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end

      if (capture) begin
        if (owner_cpu_q) begin
          cpu_data <= ram_rd_data;
        end else begin
          vga_data <= ram_rd_data;
        end
      end

      // Streak counts VGA wins that made the CPU wait; it saturates so the
      // CPU grant condition stays true until the CPU is actually served.
      if (grant_cpu) begin
        streak_q <= '0;
      end else if (state_q == S_IDLE && !cpu_access) begin
        streak_q <= '0;
      end else if (grant_vga && streak_q != STREAK_MAX) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end

  assign vga_ack = (state_q == S_ACK) && !owner_cpu_q;
  assign cpu_ack = (state_q == S_ACK) &&  owner_cpu_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
//   Directed bench for fb_arbiter with a behavioural RAM model. Expected read
//   data is pushed to per-port queues when a request is driven and popped when
//   the matching ack appears. Inputs change and outputs are sampled on the
//   falling edge of sys_clk.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

  localparam int RAM_LATENCY = 1;
  localparam int VGA_BURST   = 8;

  typedef struct packed {
    logic        chk;   // 1: compare data on ack (reads); 0: write ack
    logic [15:0] data;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        vga_access;
  logic [15:0] vga_address;
  logic        vga_ack;
  logic [15:0] vga_data;
  logic        cpu_access;
  logic        cpu_wr_en;
  logic [15:0] cpu_address;
  logic [1:0]  cpu_bytesel;
  logic [15:0] cpu_wr_data;
  logic        cpu_ack;
  logic [15:0] cpu_data;
  logic [15:0] ram_address;
  logic        ram_wr_en;
  logic [1:0]  ram_bytesel;
  logic [15:0] ram_wr_data;
  logic [15:0] ram_rd_data;

  fb_arbiter #(
    .RAM_LATENCY(RAM_LATENCY),
    .VGA_BURST  (VGA_BURST)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .vga_access (vga_access),
    .vga_address(vga_address),
    .vga_ack    (vga_ack),
    .vga_data   (vga_data),
    .cpu_access (cpu_access),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_address(cpu_address),
    .cpu_bytesel(cpu_bytesel),
    .cpu_wr_data(cpu_wr_data),
    .cpu_ack    (cpu_ack),
    .cpu_data   (cpu_data),
    .ram_address(ram_address),
    .ram_wr_en  (ram_wr_en),
    .ram_bytesel(ram_bytesel),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------------------
  // RAM model: power-up contents {8'h5A, addr[7:0]}, byte-masked writes,
  // read data RAM_LATENCY cycles after the address is presented.
  // ---------------------------------------------------------------------------
  logic [15:0] mem [0:65535];
  logic        mem_ready = 1'b0;
  logic [15:0] rd_pipe [RAM_LATENCY];

  function automatic logic [15:0] merge(input logic [15:0] old_w,
                                        input logic [1:0]  be,
                                        input logic [15:0] new_w);
    logic [15:0] r;
    r = old_w;
    if (be[1]) r[15:8] = new_w[15:8];
    if (be[0]) r[7:0]  = new_w[7:0];
    return r;
  endfunction

  always @(posedge sys_clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) begin
        mem[i] <= {8'h5A, 8'(i)};
      end
      mem_ready <= 1'b1;
    end else if (ram_wr_en) begin
      mem[ram_address] <= merge(mem[ram_address], ram_bytesel, ram_wr_data);
    end
    rd_pipe[0] <= mem[ram_address];
    for (int i = 1; i < RAM_LATENCY; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign ram_rd_data = rd_pipe[RAM_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vga_ack_cnt = 0;
  int   cpu_ack_cnt = 0;
  int   wr_cnt = 0;
  exp_t vga_q[$];
  exp_t cpu_q[$];
  int   ack_log[$];   // 0 = VGA ack, 1 = CPU ack
  int   ack_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t rd_exp(input logic [15:0] d);
    return exp_t'{chk: 1'b1, data: d};
  endfunction

  function automatic exp_t wr_exp();
    return exp_t'{chk: 1'b0, data: 16'h0000};
  endfunction

  // Advance to the next falling edge and run the per-cycle scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge sys_clk);
    cyc++;
    if (!reset) begin
      check("single_ack", 32'(vga_ack & cpu_ack), 32'd0);
      check("streak_bound", 32'(int'(dut.streak_q) <= VGA_BURST), 32'd1);
      if (ram_wr_en) wr_cnt++;
      if (vga_ack) begin
        vga_ack_cnt++;
        ack_log.push_back(0);
        ack_cyc.push_back(cyc);
        if (vga_q.size() == 0) begin
          check("vga_unexpected_ack", 32'(vga_q.size()), 32'd1);
        end else begin
          e = vga_q.pop_front();
          if (e.chk) check("vga_sb_data", 32'(vga_data), 32'(e.data));
        end
      end
      if (cpu_ack) begin
        cpu_ack_cnt++;
        ack_log.push_back(1);
        ack_cyc.push_back(cyc);
        if (cpu_q.size() == 0) begin
          check("cpu_unexpected_ack", 32'(cpu_q.size()), 32'd1);
        end else begin
          e = cpu_q.pop_front();
          if (e.chk) check("cpu_sb_data", 32'(cpu_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_vga_ack"},     32'(vga_ack),     32'd0);
    check({pfx, "_cpu_ack"},     32'(cpu_ack),     32'd0);
    check({pfx, "_vga_data"},    32'(vga_data),    32'd0);
    check({pfx, "_cpu_data"},    32'(cpu_data),    32'd0);
    check({pfx, "_ram_address"}, 32'(ram_address), 32'd0);
    check({pfx, "_ram_wr_en"},   32'(ram_wr_en),   32'd0);
    check({pfx, "_ram_bytesel"}, 32'(ram_bytesel), 32'd0);
    check({pfx, "_ram_wr_data"}, 32'(ram_wr_data), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          w0;
    int          v0;
    int          c0;
    int          base;
    int          n;
    logic [15:0] addr;

    reset       = 1'b1;
    vga_access  = 1'b0;
    vga_address = 16'h0000;
    cpu_access  = 1'b0;
    cpu_wr_en   = 1'b0;
    cpu_address = 16'h0000;
    cpu_bytesel = 2'b00;
    cpu_wr_data = 16'h0000;

    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;

    // VGA-only read: ack in cycle 3 only, no writes, no CPU ack.
    w0 = wr_cnt;
    tick();
    vga_access  = 1'b1;
    vga_address = 16'h0050;
    vga_q.push_back(rd_exp(16'h5A50));
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t1_vga_ack", 32'(vga_ack), 32'(c == 3));
      check("t1_cpu_ack", 32'(cpu_ack), 32'd0);
      if (c == 3) begin
        check("t1_vga_data", 32'(vga_data), 32'h5A50);
        vga_access = 1'b0;
      end
    end
    check("t1_no_write", 32'(wr_cnt - w0), 32'd0);

    // CPU write 0x1000 <= 0xABCD, high byte only.
    tick();
    cpu_access  = 1'b1;
    cpu_wr_en   = 1'b1;
    cpu_address = 16'h1000;
    cpu_bytesel = 2'b10;
    cpu_wr_data = 16'hABCD;
    cpu_q.push_back(wr_exp());
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t2_ram_wr_en", 32'(ram_wr_en), 32'(c == 1));
      check("t2_cpu_ack", 32'(cpu_ack), 32'(c == 2));
      if (c == 1) begin
        check("t2_ram_address", 32'(ram_address), 32'h1000);
        check("t2_ram_bytesel", 32'(ram_bytesel), 32'h2);
        check("t2_ram_wr_data", 32'(ram_wr_data), 32'hABCD);
      end
      if (c == 2) begin
        cpu_access = 1'b0;
        cpu_wr_en  = 1'b0;
      end
    end

    // Simultaneous VGA read and CPU read with streak 0: VGA first, CPU at 8.
    tick();
    vga_access  = 1'b1;
    vga_address = 16'h0060;
    vga_q.push_back(rd_exp(16'h5A60));
    cpu_access  = 1'b1;
    cpu_wr_en   = 1'b0;
    cpu_address = 16'h1000;
    cpu_q.push_back(rd_exp(16'hAB00));
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("t3_vga_ack", 32'(vga_ack), 32'(c == 3));
      check("t3_cpu_ack", 32'(cpu_ack), 32'(c == 8));
      if (c == 3) vga_access = 1'b0;
      if (c == 8) begin
        check("t3_cpu_data", 32'(cpu_data), 32'hAB00);
        cpu_access = 1'b0;
      end
    end

    // Starvation: VGA streams addresses 0..15, CPU waits on a read of 0x2000.
    tick();
    base = ack_log.size();
    v0   = vga_ack_cnt;
    c0   = cpu_ack_cnt;
    addr = 16'h0000;
    vga_access  = 1'b1;
    vga_address = addr;
    vga_q.push_back(rd_exp({8'h5A, addr[7:0]}));
    cpu_access  = 1'b1;
    cpu_wr_en   = 1'b0;
    cpu_address = 16'h2000;
    cpu_q.push_back(rd_exp(16'h5A00));
    n = 0;
    while (vga_access || cpu_access) begin
      tick();
      n++;
      if (n > 300) begin
        check("t4_budget_vga_acks", 32'(vga_ack_cnt - v0), 32'd16);
        vga_access = 1'b0;
        cpu_access = 1'b0;
        break;
      end
      if (vga_ack) begin
        if (addr == 16'd15) begin
          vga_access = 1'b0;
        end else begin
          addr = addr + 16'd1;
          vga_address = addr;
          vga_q.push_back(rd_exp({8'h5A, addr[7:0]}));
        end
      end
      if (cpu_ack) cpu_access = 1'b0;
    end
    tick();
    check("t4_vga_ack_count", 32'(vga_ack_cnt - v0), 32'd16);
    check("t4_cpu_ack_count", 32'(cpu_ack_cnt - c0), 32'd1);
    if (ack_log.size() >= base + 10) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t4_order_%0d", i), 32'(ack_log[base + i]), 32'd0);
      end
      check("t4_order_cpu", 32'(ack_log[base + 8]), 32'd1);
      check("t4_order_resume", 32'(ack_log[base + 9]), 32'd0);
      check("t4_read_period", 32'(ack_cyc[base + 1] - ack_cyc[base]), 32'(RAM_LATENCY + 4));
      check("t4_cpu_slot", 32'(ack_cyc[base + 8] - ack_cyc[base + 7]), 32'(RAM_LATENCY + 4));
    end else begin
      check("t4_ack_log_len", 32'(ack_log.size() - base), 32'd17);
    end

    // Reset during WAIT of a CPU read: everything drops, then a full re-serve.
    tick();
    cpu_access  = 1'b1;
    cpu_wr_en   = 1'b0;
    cpu_address = 16'h0070;
    tick();   // cycle 1, ISSUE
    tick();   // cycle 2, WAIT
    reset = 1'b1;
    #1;
    check_all_zero("t5_rst");
    for (int c = 0; c < 2; c++) begin
      tick();
      check("t5_rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("t5_rst_vga_ack", 32'(vga_ack), 32'd0);
    end
    reset = 1'b0;
    cpu_q.push_back(rd_exp(16'h5A70));
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t5_cpu_ack", 32'(cpu_ack), 32'(c == 3));
      if (c == 3) begin
        check("t5_cpu_data", 32'(cpu_data), 32'h5A70);
        cpu_access = 1'b0;
      end
    end

    // CPU keeps access high for one cycle after its ack: one ack, one write.
    tick();
    w0 = wr_cnt;
    c0 = cpu_ack_cnt;
    cpu_access  = 1'b1;
    cpu_wr_en   = 1'b1;
    cpu_address = 16'h0080;
    cpu_bytesel = 2'b01;
    cpu_wr_data = 16'h1234;
    cpu_q.push_back(wr_exp());
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("t6_cpu_ack", 32'(cpu_ack), 32'(c == 2));
      if (c == 4) begin
        cpu_access = 1'b0;
        cpu_wr_en  = 1'b0;
      end
    end
    check("t6_write_count", 32'(wr_cnt - w0), 32'd1);
    check("t6_ack_count", 32'(cpu_ack_cnt - c0), 32'd1);

    // Read back the low-byte write; the address then holds between accesses.
    cpu_access  = 1'b1;
    cpu_wr_en   = 1'b0;
    cpu_address = 16'h0080;
    cpu_q.push_back(rd_exp(16'h5A34));
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("t7_cpu_ack", 32'(cpu_ack), 32'(c == 3));
      if (c == 3) cpu_access = 1'b0;
    end
    check("t7_addr_hold", 32'(ram_address), 32'h0080);
    check("t7_wr_en_idle", 32'(ram_wr_en), 32'd0);
    check("t7_cpu_data_hold", 32'(cpu_data), 32'h5A34);

    check("end_vga_queue_empty", 32'(vga_q.size()), 32'd0);
    check("end_cpu_queue_empty", 32'(cpu_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Arbitrates a single-port framebuffer RAM between two requesters in the sys_clk domain.
- Requester 1 is the VGA framebuffer prefetcher, which issues read-only, word-addressed bursts of one row at a time.
- Requester 2 is the CPU video-memory bus, which issues reads and byte-masked writes.
- The VGA port has priority; a bounded-streak rule stops the CPU from being starved during prefetch bursts.

Parameters:
- RAM_LATENCY, 1: cycles from ram_address presented to ram_rd_data valid (1..4).
- VGA_BURST, 8: maximum consecutive VGA grants while the CPU is waiting, before the CPU is forced in.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- vga_access  in  1  prefetch read request; held until vga_ack.
- vga_address  in  16  prefetch word address.
- vga_ack  out  1  one-cycle completion pulse.
- vga_data  out  16  read data, valid while vga_ack=1.
- cpu_access  in  1  CPU request; held until cpu_ack, may stay high for one cycle after it.
- cpu_wr_en  in  1  1=write, 0=read.
- cpu_address  in  16  CPU word address.
- cpu_bytesel  in  2  byte enables, [1]=high byte.
- cpu_wr_data  in  16  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_data  out  16  read data, valid while cpu_ack=1.
- ram_address  out  16  registered RAM address.
- ram_wr_en  out  1  registered write strobe.
- ram_bytesel  out  2  registered byte enables.
- ram_wr_data  out  16  registered write data.
- ram_rd_data  in  16  RAM read data.

Behaviour:
- Reset values: all outputs 0; state=IDLE; streak=0.
- Reset mid-operation aborts the access: no ack is issued and the RAM strobes drop immediately.
- States: IDLE -> ISSUE -> WAIT (reads only) -> ACK -> GAP -> IDLE.
- Requests are sampled only in IDLE. Cycle numbering below counts from that IDLE cycle as cycle 0.
- IDLE with no request: stay in IDLE.
- IDLE with a request: grant as follows.
  - Only one port requesting: that port wins.
  - Both requesting and streak<VGA_BURST: VGA wins.
  - Both requesting and streak==VGA_BURST: CPU wins.
  - The winner's address, bytesel and data are registered onto the ram_* outputs at the end of cycle 0.
  - VGA grants force ram_bytesel=2'b11 and ram_wr_en=0.
- ISSUE (cycle 1): RAM outputs are presented.
  - Write: ram_wr_en=1 for this cycle only, then go to ACK.
  - Read: go to WAIT.
- WAIT: a down-counter loaded with RAM_LATENCY-1.
  - ram_rd_data is valid in cycle 1+RAM_LATENCY and is captured into the granted port's data register at the end of that cycle.
- ACK: the granted port's ack=1 for exactly one cycle, with data held stable.
  - Write ack lands in cycle 2.
  - Read ack lands in cycle 2+RAM_LATENCY.
  - The non-granted port's ack stays 0.
- GAP: one dead cycle so a requester still holding access in the cycle after its ack is not re-granted. Then return to IDLE.
- Back-to-back throughput:
  - Read period: RAM_LATENCY+4 cycles.
  - Write period: 4 cycles.
- ram_address holds its last value between accesses; ram_wr_en is 0 outside ISSUE.
- Data registers are updated only on a capture and hold between accesses.
- Streak counter is $clog2(VGA_BURST+1) bits wide and saturates at VGA_BURST.
  - Increments on a VGA grant while cpu_access=1.
  - Cleared on any CPU grant.
  - Cleared in an IDLE cycle with cpu_access=0.
- Addresses pass through unmodified; there is no wrap or offset arithmetic.

Test Plan:
- VGA-only read: RAM_LATENCY=1, vga_address=16'h0050, RAM model returns 16'h5A50.
  - vga_ack is high only in cycle 3, with vga_data=16'h5A50.
  - ram_wr_en never rises; cpu_ack stays 0.
- CPU write: address 16'h1000, bytesel 2'b10, data 16'hABCD.
  - ram_wr_en=1 in cycle 1 only, with ram_bytesel=2'b10 and ram_wr_data=16'hABCD.
  - cpu_ack is high in cycle 2.
- Simultaneous VGA read and CPU read in the same IDLE cycle, streak=0.
  - VGA is acked first.
  - The CPU is acked in the next access slot (cycle 8 with RAM_LATENCY=1).
- Starvation check: vga_access held continuously over addresses 0..15, cpu_access held for a read at 16'h2000.
  - Exactly 8 vga_acks occur, then 1 cpu_ack, then VGA resumes.
  - The streak never exceeds 8.
- Reset asserted during WAIT.
  - All outputs are 0 immediately and no ack is issued.
  - After release, the still-pending CPU request is served from IDLE with a full-latency ack.
- CPU holds cpu_access for one cycle after cpu_ack.
  - Exactly one cpu_ack and exactly one RAM write occur (GAP state is exercised).
